mul66_seq_sched: RTL and testbench

Iterative scheduler for the 66×66 unsigned multiplier. It time-multiplexes a single 22×22 DSP product across the nine partial products (3 limbs × 3 limbs, `INTERVAL` = 22) and accumulates them into a 132-bit result. Operands arrive through a valid/ready handshake and the product leaves through one. It replaces the nine-DSP combinational array where DSP budget matters and feeds the same downstream consumers: the upper-2-bit and middle-64-bit fields.

---
 rtl/mul66_seq_sched.sv | 139 +++++++++++++
 tb/tb_mul66_seq_sched.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mul66_seq_sched.sv
// Iterative 66x66 unsigned multiplier: one 22x22 product per cycle over nine limb pairs, accumulated into 132 bits.
// Accept edge to out_valid is 10 edges (9 MUL + 1 DRAIN); DONE holds prod stable until out_ready, in_ready low while busy.
module mul66_seq_sched #(
  parameter int MUL_SIZE = 66,
  parameter int INTERVAL = 22
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [MUL_SIZE-1:0]     a,
  input  logic [MUL_SIZE-1:0]     b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*MUL_SIZE-1:0]   prod,
  output logic [1:0]              prod_hi2,
  output logic [63:0]             prod_mid64,
  output logic                    busy
);

  localparam int PW = 2 * MUL_SIZE;
  localparam int DW = 2 * INTERVAL;
  localparam int SW = $clog2(PW);

  typedef enum logic [1:0] {IDLE, MUL, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            k_q, k_d;
  logic [MUL_SIZE-1:0]   a_q, a_d, b_q, b_d;
  logic [DW-1:0]         p_q, p_d;
  logic [SW-1:0]         s_q, s_d;
  logic                  p_vld_q, p_vld_d;
  logic [PW-1:0]         acc_q, acc_d;

  logic [1:0]            limb_i, limb_j;
  logic [INTERVAL-1:0]   a_limb, b_limb;
  logic [PW-1:0]         addend;

  // Row-major step decode: k -> (k/3, k%3)
  always_comb begin
    limb_i = 2'd0;
    limb_j = 2'd0;
    if (k_q >= 4'd6) begin
      limb_i = 2'd2;
      limb_j = 2'(k_q - 4'd6);
    end else if (k_q >= 4'd3) begin
      limb_i = 2'd1;
      limb_j = 2'(k_q - 4'd3);
    end else begin
      limb_j = 2'(k_q);
    end
  end

  always_comb begin
    case (limb_i)
      2'd0:    a_limb = a_q[0 +: INTERVAL];
      2'd1:    a_limb = a_q[INTERVAL +: INTERVAL];
      default: a_limb = a_q[2*INTERVAL +: INTERVAL];
    endcase
    case (limb_j)
      2'd0:    b_limb = b_q[0 +: INTERVAL];
      2'd1:    b_limb = b_q[INTERVAL +: INTERVAL];
      default: b_limb = b_q[2*INTERVAL +: INTERVAL];
    endcase
  end

  // The product registered last cycle is folded in at its own weight.
  assign addend = PW'(p_q) << s_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    s_d     = s_q;
    p_vld_d = p_vld_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          k_d     = 4'd0;
          p_vld_d = 1'b0;
          state_d = MUL;
        end
      end
      MUL: begin
        p_d     = DW'(a_limb) * DW'(b_limb);
        s_d     = (SW'(limb_i) + SW'(limb_j)) * SW'(INTERVAL);
        p_vld_d = 1'b1;
        if (p_vld_q) acc_d = acc_q + addend;
        k_d     = k_q + 4'd1;
        if (k_q == 4'd8) state_d = DRAIN;
      end
      DRAIN: begin
        if (p_vld_q) acc_d = acc_q + addend;
        p_vld_d = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      s_q     <= '0;
      p_vld_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      s_q     <= s_d;
      p_vld_q <= p_vld_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign prod       = acc_q;
  assign prod_hi2   = acc_q[PW-1 -: 2];
  assign prod_mid64 = acc_q[PW-5 -: 64];

endmodule

// File: tb/tb_mul66_seq_sched.sv
// Scoreboard bench for mul66_seq_sched: directed corner cases, backpressure, mid-run reset and a random sweep.
module tb_mul66_seq_sched;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [65:0]   a;
  logic [65:0]   b;
  logic          out_valid;
  logic          out_ready;
  logic [131:0]  prod;
  logic [1:0]    prod_hi2;
  logic [63:0]   prod_mid64;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int pending = 0;
  logic ov_prev = 1'b0;
  logic [131:0] sb[$];

  mul66_seq_sched #(.MUL_SIZE(66), .INTERVAL(22)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .prod(prod), .prod_hi2(prod_hi2), .prod_mid64(prod_mid64), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [131:0] got, input logic [131:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts can only be granted in IDLE, so outputs must never appear without one.
  always @(negedge clk) begin
    if (rst) begin
      pending = 0;
    end else begin
      if (out_valid && !ov_prev) chk("ov_no_accept", (pending > 0) ? 132'd1 : 132'd0, 132'd1);
      if (in_valid && in_ready) pending++;
      if (out_valid && out_ready) pending--;
    end
    ov_prev = out_valid;
  end

  task automatic send(input logic [65:0] va, input logic [65:0] vb, input logic [131:0] exp);
    int n;
    n = 0;
    a = va;
    b = vb;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 132'd0, 132'd1);
    end else begin
      sb.push_back(exp);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic recv(input int gap);
    int n;
    logic [131:0] e;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      chk("out_valid_timeout", 132'd0, 132'd1);
      return;
    end
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 132'd0, 132'd1);
      return;
    end
    e = sb.pop_front();
    chk("prod", prod, e);
    chk("prod_hi2", 132'(prod_hi2), 132'(e[131:130]));
    chk("prod_mid64", 132'(prod_mid64), 132'(e[127:64]));
    for (int g = 0; g < gap; g++) begin
      tick();
      chk("hold_prod", prod, e);
      chk("hold_in_ready", 132'(in_ready), 132'd0);
      chk("hold_out_valid", 132'(out_valid), 132'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 132'(in_ready), 132'd1);
    chk({tag, "_out_valid"}, 132'(out_valid), 132'd0);
    chk({tag, "_busy"}, 132'(busy), 132'd0);
    chk({tag, "_prod"}, prod, 132'd0);
    chk({tag, "_hi2"}, 132'(prod_hi2), 132'd0);
    chk({tag, "_mid64"}, 132'(prod_mid64), 132'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int ov_cnt;
    logic [95:0]  r;
    logic [65:0]  ra, rb;
    logic [131:0] full_exp;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();
    chk("idle_in_ready", 132'(in_ready), 132'd1);

    // Basic product and exact latency from the accept edge
    send(66'd3, 66'd5, 132'd15);
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    chk("latency", 132'(n), 132'd10);
    recv(0);

    send(66'd1 << 22, 66'd1 << 44, 132'd1 << 66);
    recv(0);

    full_exp = {132{1'b1}} - (132'd1 << 67) + 132'd2;
    send({66{1'b1}}, {66{1'b1}}, full_exp);
    recv(0);

    // Backpressure with a second pair held through DONE
    send(66'd7, 66'd9, 132'd63);
    a = 66'd1;
    b = 66'd1;
    in_valid = 1'b1;
    recv(6);
    chk("bp_idle_gap_busy", 132'(busy), 132'd0);
    chk("bp_idle_gap_in_ready", 132'(in_ready), 132'd1);
    sb.push_back(132'd1);
    tick();
    chk("bp_second_accept", 132'(busy), 132'd1);
    in_valid = 1'b0;
    recv(0);

    // Reset during MUL discards the operation
    send(66'd1 << 65, 66'd1 << 65, 132'd1 << 130);
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    sb.delete();
    tick();
    rst = 1'b0;
    ov_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) ov_cnt++;
    end
    chk("midrst_no_out_valid", 132'(ov_cnt), 132'd0);
    send(66'd12345, 66'd678, 132'd8369910);
    recv(0);

    for (int t = 0; t < 1000; t++) begin
      r = {$urandom(), $urandom(), $urandom()};
      ra = r[65:0];
      r = {$urandom(), $urandom(), $urandom()};
      rb = r[65:0];
      if (t % 50 == 0) ra = {66{1'b1}};
      if ($urandom_range(0, 3) == 0) tick();
      send(ra, rb, 132'(ra) * 132'(rb));
      recv(int'($urandom_range(0, 3)));
    end
    chk("sb_drained", 132'(sb.size()), 132'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
